parity_frame_accumulator: RTL and testbench

Streaming parity unit that generalises the team's four-input XOR/XNOR gate lab blocks to a parametrised, clocked datapath. It accepts WIDTH-bit words over a valid/ready handshake and accumulates a column-wise XOR over frames of up to DEPTH words. For each frame it emits the folded column word, a single even/odd parity bit and the word count. It sits between a word source (switch/test-pattern front end) and a display or checker sink.

---
 rtl/parity_pkg.sv | 21 ++
 rtl/parity_word_reduce.sv | 21 ++
 rtl/parity_frame_accumulator.sv | 136 +++++++++++++
 tb/tb_parity_frame_accumulator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame accumulator: FSM state
// encoding and the counter-width function.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2, used at elaboration time to size the word counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_word_reduce.sv
// Combinational WIDTH-bit parity reduce: XOR chain across the word, inverted
// at the end when odd mode is selected.
module parity_word_reduce #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    output logic             parity
);

    logic chain;

    always_comb begin
        chain = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            chain = chain ^ data[i];
        end
        parity = chain ^ mode;
    end

endmodule

// File: rtl/parity_frame_accumulator.sv
// Streaming column-XOR accumulator: folds up to DEPTH words per frame and
// presents the folded word, its parity and the word count on a valid/ready port.
module parity_frame_accumulator
    import parity_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             odd,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on the partner's valid.

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   out_word_q, out_word_d;
    logic               out_parity_q, out_parity_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    logic               accept;
    logic               close;
    logic [CNT_W-1:0]   count_inc;
    logic               parity_next;

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        mode_d  = mode_q;
        close   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    count_d = CNT_W'(1);
                    mode_d  = odd;
                    close   = flush || (CNT_W'(1) == FULL_COUNT);
                    state_d = close ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d   = acc_q ^ in_data;
                    count_d = count_inc;
                    close   = flush || (count_inc == FULL_COUNT);
                    state_d = close ? ST_DONE : ST_ACC;
                end else if (flush) begin
                    close   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // Parity is taken from the value about to be latched, so the result
    // registers are complete on the same edge that closes the frame.
    parity_word_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .data   (acc_d),
        .mode   (mode_d),
        .parity (parity_next)
    );

    always_comb begin
        out_word_d   = out_word_q;
        out_parity_d = out_parity_q;
        out_count_d  = out_count_q;
        if (close) begin
            out_word_d   = acc_d;
            out_parity_d = parity_next;
            out_count_d  = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            mode_q       <= 1'b0;
            out_word_q   <= '0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            out_word_q   <= out_word_d;
            out_parity_q <= out_parity_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_word   = out_word_q;
    assign out_parity = out_parity_q;
    assign out_count  = out_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_parity_frame_accumulator.sv
// Randomised scoreboard bench for parity_frame_accumulator (WIDTH=4, DEPTH=4),
// with directed cases for back-pressure, flush and asynchronous reset.
module tb_parity_frame_accumulator;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int EW    = WIDTH + 1 + CW;

    logic             clk = 1'b0;
    logic             rst;
    logic             odd;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic [1:0]       dbg_state;

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic hold_sink = 1'b0;
    logic rand_sink = 1'b0;

    parity_frame_accumulator #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .odd        (odd),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_parity (out_parity),
        .out_count  (out_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Reference: fold words, parity from the number of set bits, count of words.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] words[4], input int n,
                                            input logic mode);
        logic [WIDTH-1:0] w;
        logic             p;
        w = '0;
        for (int i = 0; i < n; i++) w = w ^ words[i];
        p = (($countones(w) % 2) == 1) ? ~mode : mode;
        return {w, p, CW'(n)};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_word(input logic [WIDTH-1:0] d, input logic fl);
        logic got;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        got      = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] words[4], input int n,
                              input logic fl_last, input logic fl_alone,
                              input logic odd_v, input logic toggle,
                              input logic gaps, input logic push);
        if (push) exp_q.push_back(model(words, n, odd_v));
        odd = odd_v;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                flush    = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (i > 0) odd = toggle ? ~odd_v : 1'($urandom_range(0, 1));
            drive_word(words[i], fl_last && (i == n - 1));
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (fl_alone) begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        check("close_valid", 32'(out_valid), 32'd1);
        check("close_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(in_ready && !out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_word"}, 32'(out_word), 32'd0);
        check({tag, "_out_parity"}, 32'(out_parity), 32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- sink ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_sink)      out_ready = 1'b0;
            else if (rand_sink) out_ready = 1'($urandom_range(0, 1));
            else                out_ready = 1'b1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'({out_word, out_parity, out_count}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", 32'(out_word), 32'(e[EW-1 -: WIDTH]));
                    check("sb_parity", 32'(out_parity), 32'(e[CW]));
                    check("sb_count", 32'(out_count), 32'(e[CW-1:0]));
                    check("sb_in_ready", 32'(in_ready), 32'd0);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH-1:0] wv[4];
        int n;
        logic fa, fl;
        int k;

        rst = 1'b1; odd = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames from the directed list.
        wv = '{4'h1, 4'h2, 4'h4, 4'h8};
        send_frame(wv, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(wv, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wv = '{4'h3, 4'h5, 4'h0, 4'h1};
        send_frame(wv, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wv = '{4'h7, 4'h1, 4'h0, 4'h0};
        send_frame(wv, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wv = '{4'h1, 4'h2, 4'h4, 4'h8};
        send_frame(wv, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Flush alone in IDLE must not open or close a frame.
        wait_idle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("idle_flush_valid", 32'(out_valid), 32'd0);
        check("idle_flush_state", 32'(dbg_state), 32'd0);

        // Back-pressure: result must hold for 5 cycles while the sink stalls.
        @(negedge clk);
        hold_sink = 1'b1;
        @(posedge clk);
        #1;
        wv = '{4'h3, 4'h5, 4'h0, 4'h1};
        send_frame(wv, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_word", 32'(out_word), 32'h7);
            check("hold_parity", 32'(out_parity), 32'd1);
            check("hold_count", 32'(out_count), 32'd4);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        hold_sink = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Reset between edges in the middle of a frame.
        odd = 1'b1;
        drive_word(4'h3, 1'b0);
        drive_word(4'h6, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wv = '{4'h1, 4'h1, 4'h1, 4'h1};
        send_frame(wv, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while a result is pending: it must be discarded.
        wait_idle();
        @(negedge clk);
        hold_sink = 1'b1;
        @(posedge clk);
        #1;
        wv = '{4'h9, 4'h4, 4'h2, 4'h0};
        send_frame(wv, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("done_rst");
        @(negedge clk);
        hold_sink = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomised frames with random sink back-pressure and input gaps.
        rand_sink = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < 4; i++) wv[i] = WIDTH'($urandom_range(0, 15));
            if (n < DEPTH) begin
                fa = 1'($urandom_range(0, 1));
                fl = ~fa;
            end else begin
                fa = 1'b0;
                fl = 1'($urandom_range(0, 1));
            end
            send_frame(wv, n, fl, fa, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
        end
        rand_sink = 1'b0;

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
